// File: rtl/pwr_seq_pkg.sv
// rtl/pwr_seq_pkg.sv - state encoding and output decode for the power sequencer
package pwr_seq_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    OFF       = 3'd0,
    PWR_UP    = 3'd1,
    RST_HOLD  = 3'd2,
    WAIT_LOCK = 3'd3,
    READY     = 3'd4,
    RETRY_OFF = 3'd5,
    FAULT     = 3'd6
  } state_e;

  typedef struct packed {
    logic pwr_en;
    logic rst_n;
    logic ready;
    logic fault;
  } outs_t;

  function automatic outs_t decode_outs(input state_e s);
    outs_t o;
    o = '0;
    case (s)
      PWR_UP, RST_HOLD: o.pwr_en = 1'b1;
      WAIT_LOCK: begin
        o.pwr_en = 1'b1;
        o.rst_n  = 1'b1;
      end
      READY: begin
        o.pwr_en = 1'b1;
        o.rst_n  = 1'b1;
        o.ready  = 1'b1;
      end
      FAULT:   o.fault = 1'b1;
      default: o = '0;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchronizer for a single asynchronous status bit
module sync_2ff (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/pwr_seq_ctrl.sv
// rtl/pwr_seq_ctrl.sv - power-up sequencer for one external device with lock timeout and retry
module pwr_seq_ctrl
  import pwr_seq_pkg::*;
#(
  parameter int CNT_W     = 32,
  parameter int T_PWR_CYC = 1200000,
  parameter int T_RST_CYC = 10000,
  parameter int T_LOCK_TO = 2000000,
  parameter int RETRY_MAX = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               pwrdwn,
  input  logic               lock,
  output logic               dev_pwr_en,
  output logic               dev_rst_n,
  output logic               ready,
  output logic               fault,
  output logic [1:0]         retry_cnt,
  output logic [STATE_W-1:0] state
);

  localparam logic [CNT_W-1:0] PWR_LAST  = CNT_W'(T_PWR_CYC - 1);
  localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(T_RST_CYC - 1);
  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(T_LOCK_TO - 1);
  localparam logic [1:0]       RETRY_LIM = 2'(RETRY_MAX);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       retry_q, retry_d;
  outs_t            outs_q, outs_d;
  logic             lock_s;

  sync_2ff u_lock_sync (
    .clk   (clk),
    .reset (reset),
    .d     (lock),
    .q     (lock_s)
  );

  always_comb begin
    state_d = state_q;
    retry_d = retry_q;
    case (state_q)
      OFF:       if (!pwrdwn) state_d = PWR_UP;
      PWR_UP:    if (cnt_q == PWR_LAST) state_d = RST_HOLD;
      RST_HOLD:  if (cnt_q == RST_LAST) state_d = WAIT_LOCK;
      WAIT_LOCK: begin
        // lock takes precedence over a timeout landing on the same cycle
        if (lock_s) begin
          state_d = READY;
        end else if (cnt_q == LOCK_LAST) begin
          if (retry_q < RETRY_LIM) begin
            retry_d = retry_q + 2'd1;
            state_d = RETRY_OFF;
          end else begin
            state_d = FAULT;
          end
        end
      end
      READY:     if (!lock_s) state_d = WAIT_LOCK;
      RETRY_OFF: if (cnt_q == RST_LAST) state_d = PWR_UP;
      FAULT:     state_d = FAULT;
      default:   state_d = OFF;
    endcase

    if (pwrdwn) begin
      state_d = OFF;
      retry_d = 2'd0;
    end
  end

  // Untimed states park the counter at zero so it can never wrap.
  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (state_d != state_q || state_q == OFF || state_q == READY || state_q == FAULT) begin
      cnt_d = '0;
    end
  end

  always_comb begin
    outs_d = decode_outs(state_d);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= OFF;
      cnt_q   <= '0;
      retry_q <= 2'd0;
      outs_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      retry_q <= retry_d;
      outs_q  <= outs_d;
    end
  end

  assign dev_pwr_en = outs_q.pwr_en;
  assign dev_rst_n  = outs_q.rst_n;
  assign ready      = outs_q.ready;
  assign fault      = outs_q.fault;
  assign retry_cnt  = retry_q;
  assign state      = state_q;

endmodule
